// File: rtl/jogo_memoria_pkg.sv
// Shared state codes, LFSR taps and button helpers for jogo_memoria_param.
package jogo_memoria_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_GERA    = 4'd1,
    ST_MOSTRA  = 4'd2,
    ST_ESPERA  = 4'd3,
    ST_PROXIMA = 4'd4,
    ST_GANHOU  = 4'd5,
    ST_PERDEU  = 4'd6
  } estado_t;

  // Feedback taps 16,14,13,11 as a mask over q[15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int MAX_BOTOES = 8;

  function automatic logic [MAX_BOTOES-1:0] onehot(input logic [2:0] idx);
    logic [MAX_BOTOES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic is_single_bit(input logic [MAX_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - MAX_BOTOES'(1))) == '0);
  endfunction

endpackage

// File: rtl/jogo_memoria_param_lfsr16.sv
// 16-bit Fibonacci LFSR, loaded with seed on reset and free-running afterwards.
module lfsr16
  import jogo_memoria_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
  end

  always_ff @(posedge clock) begin
    if (!reset) q_q <= seed;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jogo_memoria_param.sv
// Parametrised memory-game engine: generate, replay, check presses, detect loss.
// Timeout detection is built only when JOGO_MEMORIA_TIMEOUT_EN is defined.
module jogo_memoria_param
  import jogo_memoria_pkg::*;
#(
  parameter int          N_BOTOES       = 4,
  parameter int          DEPTH          = 16,
  parameter int          SHOW_CYCLES    = 50_000_000,
  parameter int          TIMEOUT_CYCLES = 250_000_000,
  parameter logic [15:0] SEED           = 16'hACE1,
  localparam int         IDX_W          = $clog2(N_BOTOES),
  localparam int         RW             = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic [3:0]          db_estado,
  output logic [RW-1:0]       db_rodada,
  output logic [RW-1:0]       db_endereco,
  output logic [IDX_W-1:0]    db_memoria
);

  localparam int SW = $clog2(SHOW_CYCLES) + 1;

  if (N_BOTOES < 2 || N_BOTOES > MAX_BOTOES || (N_BOTOES & (N_BOTOES - 1)) != 0 ||
      DEPTH < 2 || DEPTH > 64 || SHOW_CYCLES < 1 || TIMEOUT_CYCLES < 2 ||
      SEED == 16'd0) begin : g_param_check
    $error("jogo_memoria_param: invalid parameter set");
  end

  estado_t             estado_q, estado_d;
  logic [RW-1:0]       rodada_q, rodada_d;
  logic [RW-1:0]       endereco_q, endereco_d;
  logic [N_BOTOES-1:0] leds_q, leds_d;
  logic [N_BOTOES-1:0] botoes_prev_q, botoes_prev_d;
  logic                ganhou_q, ganhou_d;
  logic                perdeu_q, perdeu_d;
  logic                pronto_q, pronto_d;
  logic [SW-1:0]       show_cnt_q, show_cnt_d;
  logic                apagado_q, apagado_d;

  logic [15:0]         lfsr;
  logic [IDX_W-1:0]    mem_q [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_rd;
  logic [N_BOTOES-1:0] alvo;
  logic                press;
  logic                acerto;

`ifdef JOGO_MEMORIA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
`endif

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (SEED),
    .q     (lfsr)
  );

  always_comb begin
    mem_rd = mem_q[endereco_q];
    alvo   = N_BOTOES'(onehot(3'(mem_rd)));
    // A press is a rising edge of "any button down", so a held button never repeats.
    press  = (botoes_prev_q == '0) && (botoes != '0);
    acerto = is_single_bit(MAX_BOTOES'(botoes)) && (botoes == alvo);
  end

  always_comb begin
    estado_d      = estado_q;
    rodada_d      = rodada_q;
    endereco_d    = endereco_q;
    ganhou_d      = ganhou_q;
    perdeu_d      = perdeu_q;
    show_cnt_d    = show_cnt_q;
    apagado_d     = apagado_q;
    botoes_prev_d = botoes;
    mem_we        = 1'b0;
`ifdef JOGO_MEMORIA_TIMEOUT_EN
    timer_d       = timer_q;
    timeout_d     = timeout_q;
`endif

    case (estado_q)
      ST_IDLE: begin
        rodada_d   = '0;
        endereco_d = '0;
        ganhou_d   = 1'b0;
        perdeu_d   = 1'b0;
`ifdef JOGO_MEMORIA_TIMEOUT_EN
        timeout_d  = 1'b0;
`endif
        if (iniciar) estado_d = ST_GERA;
      end

      ST_GERA: begin
        mem_we = 1'b1;
        if (endereco_q == RW'(DEPTH - 1)) begin
          endereco_d = '0;
          rodada_d   = '0;
          show_cnt_d = '0;
          apagado_d  = 1'b0;
          estado_d   = ST_MOSTRA;
        end else begin
          endereco_d = endereco_q + RW'(1);
        end
      end

      // Each replayed step is an on phase followed by an equal off phase.
      ST_MOSTRA: begin
        if (show_cnt_q == SW'(SHOW_CYCLES - 1)) begin
          show_cnt_d = '0;
          if (!apagado_q) begin
            apagado_d = 1'b1;
          end else begin
            apagado_d = 1'b0;
            if (endereco_q == rodada_q) begin
              endereco_d = '0;
              estado_d   = ST_ESPERA;
`ifdef JOGO_MEMORIA_TIMEOUT_EN
              timer_d    = '0;
`endif
            end else begin
              endereco_d = endereco_q + RW'(1);
            end
          end
        end else begin
          show_cnt_d = show_cnt_q + SW'(1);
        end
      end

      ST_ESPERA: begin
        if (press) begin
          if (!acerto) begin
            estado_d = ST_PERDEU;
            perdeu_d = 1'b1;
          end else if (endereco_q == rodada_q) begin
            if (rodada_q == RW'(DEPTH - 1)) begin
              estado_d = ST_GANHOU;
              ganhou_d = 1'b1;
            end else begin
              estado_d = ST_PROXIMA;
            end
          end else begin
            endereco_d = endereco_q + RW'(1);
`ifdef JOGO_MEMORIA_TIMEOUT_EN
            timer_d    = '0;
`endif
          end
        end
`ifdef JOGO_MEMORIA_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          estado_d  = ST_PERDEU;
          perdeu_d  = 1'b1;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end

      ST_PROXIMA: begin
        if (rodada_q != RW'(DEPTH - 1)) rodada_d = rodada_q + RW'(1);
        endereco_d = '0;
        show_cnt_d = '0;
        apagado_d  = 1'b0;
        estado_d   = ST_MOSTRA;
      end

      ST_GANHOU, ST_PERDEU: begin
        if (iniciar) begin
          estado_d   = ST_GERA;
          rodada_d   = '0;
          endereco_d = '0;
          ganhou_d   = 1'b0;
          perdeu_d   = 1'b0;
`ifdef JOGO_MEMORIA_TIMEOUT_EN
          timeout_d  = 1'b0;
`endif
        end
      end

      default: estado_d = ST_IDLE;
    endcase

    leds_d = '0;
    if (estado_q == ST_MOSTRA && !apagado_q) leds_d = alvo;
    else if (estado_q == ST_ESPERA)          leds_d = botoes;

    pronto_d = (estado_d == ST_IDLE) || (estado_d == ST_GANHOU) || (estado_d == ST_PERDEU);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q      <= ST_IDLE;
      rodada_q      <= '0;
      endereco_q    <= '0;
      leds_q        <= '0;
      botoes_prev_q <= '0;
      ganhou_q      <= 1'b0;
      perdeu_q      <= 1'b0;
      pronto_q      <= 1'b1;
      show_cnt_q    <= '0;
      apagado_q     <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      rodada_q      <= rodada_d;
      endereco_q    <= endereco_d;
      leds_q        <= leds_d;
      botoes_prev_q <= botoes_prev_d;
      ganhou_q      <= ganhou_d;
      perdeu_q      <= perdeu_d;
      pronto_q      <= pronto_d;
      show_cnt_q    <= show_cnt_d;
      apagado_q     <= apagado_d;
    end
  end

`ifdef JOGO_MEMORIA_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Sequence storage has no reset; it is always rewritten in GERA before use.
  always_ff @(posedge clock) begin
    if (reset && mem_we) mem_q[endereco_q] <= IDX_W'(lfsr);
  end

  assign leds        = leds_q;
  assign pronto      = pronto_q;
  assign ganhou      = ganhou_q;
  assign perdeu      = perdeu_q;
  assign db_estado   = estado_q;
  assign db_rodada   = rodada_q;
  assign db_endereco = endereco_q;
  assign db_memoria  = mem_rd;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param with an LFSR reference model and a replay scoreboard.
module tb_jogo_memoria_param;

  localparam int          N_BOTOES       = 4;
  localparam int          DEPTH          = 4;
  localparam int          SHOW_CYCLES    = 2;
  localparam int          TIMEOUT_CYCLES = 20;
  localparam logic [15:0] SEED           = 16'hACE1;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       pronto, ganhou, perdeu, timeout;
  logic [3:0] db_estado;
  logic [1:0] db_rodada, db_endereco, db_memoria;

  jogo_memoria_param #(
    .N_BOTOES       (N_BOTOES),
    .DEPTH          (DEPTH),
    .SHOW_CYCLES    (SHOW_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SEED           (SEED)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .botoes      (botoes),
    .leds        (leds),
    .pronto      (pronto),
    .ganhou      (ganhou),
    .perdeu      (perdeu),
    .timeout     (timeout),
    .db_estado   (db_estado),
    .db_rodada   (db_rodada),
    .db_endereco (db_endereco),
    .db_memoria  (db_memoria)
  );

  always #5 clock = ~clock;

  // Reference LFSR: x^16 + x^14 + x^13 + x^11, shifting toward the MSB.
  logic [15:0] m_lfsr;
  always @(posedge clock) begin
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int         n_assert = 0;
  int         n_fail   = 0;
  int         first_wait;
  logic [1:0] exp_seq [DEPTH];
  logic [3:0] sb [$];

  function automatic logic [3:0] oh(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("gera_estado", 32'(db_estado), 1);
    chk("gera_pronto", 32'(pronto), 0);
    chk("gera_flags", 32'({ganhou, perdeu, timeout}), 0);
    for (int k = 0; k < DEPTH; k++) begin
      exp_seq[k] = m_lfsr[1:0];
      tick();
    end
    chk("post_gera_estado", 32'(db_estado), 2);
    chk("post_gera_rodada", 32'(db_rodada), 0);
    chk("post_gera_mem0", 32'(db_memoria), 32'(exp_seq[0]));
  endtask

  task automatic check_replay(input int r);
    int         w;
    logic [3:0] e;
    for (int k = 0; k <= r; k++) sb.push_back(oh(exp_seq[k]));
    for (int k = 0; k <= r; k++) begin
      w = 0;
      while (leds == 4'd0 && w < 60) begin tick(); w++; end
      if (k == 0) first_wait = w;
      e = sb.pop_front();
      chk("replay_led", 32'(leds), 32'(e));
      w = 0;
      while (leds != 4'd0 && w < 60) begin tick(); w++; end
      chk("led_on_cycles", w, SHOW_CYCLES);
    end
    w = 0;
    while (db_estado != 4'd3 && w < 60) begin tick(); w++; end
    chk("enter_espera", 32'(db_estado), 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    iniciar = 1'b0;
    botoes  = 4'd0;
    tick();
    tick();
    chk("rst_estado", 32'(db_estado), 0);
    chk("rst_pronto", 32'(pronto), 1);
    chk("rst_leds", 32'(leds), 0);
    chk("rst_flags", 32'({ganhou, perdeu, timeout}), 0);
    chk("rst_db", 32'({db_rodada, db_endereco}), 0);
    reset = 1'b1;
    tick();
    chk("idle_hold", 32'(db_estado), 0);

    // Game 1: full win.
    start_game();
    for (int r = 0; r < DEPTH; r++) begin
      check_replay(r);
      if (r == 0) chk("first_led_latency", first_wait, 1);
      for (int k = 0; k <= r; k++) begin
        botoes = oh(exp_seq[k]);
        tick();
        if (k < r) begin
          chk("mid_press_estado", 32'(db_estado), 3);
          chk("mid_press_endereco", 32'(db_endereco), k + 1);
        end else if (r < DEPTH - 1) begin
          chk("round_done_estado", 32'(db_estado), 4);
        end else begin
          chk("win_estado", 32'(db_estado), 5);
        end
        botoes = 4'd0;
        tick();
      end
    end
    tick();
    tick();
    chk("win_hold_estado", 32'(db_estado), 5);
    chk("win_ganhou", 32'(ganhou), 1);
    chk("win_rodada", 32'(db_rodada), 3);
    chk("win_pronto", 32'(pronto), 1);
    chk("win_perdeu", 32'(perdeu), 0);

    // Game 2: held button across replay, then wrong press at second step.
    start_game();
    chk("restart_ganhou_clear", 32'(ganhou), 0);
    botoes = oh(exp_seq[0]);
    check_replay(0);
    tick();
    tick();
    tick();
    chk("held_estado", 32'(db_estado), 3);
    chk("held_endereco", 32'(db_endereco), 0);
    chk("held_leds_mirror", 32'(leds), 32'(oh(exp_seq[0])));
    botoes = 4'd0;
    tick();
    botoes = oh(exp_seq[0]);
    tick();
    chk("after_release_press", 32'(db_estado), 4);
    botoes = 4'd0;
    tick();
    check_replay(1);
    botoes = oh(exp_seq[0]);
    tick();
    chk("r1_first_ok", 32'(db_endereco), 1);
    botoes  = 4'd0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("iniciar_ignored_espera", 32'(db_estado), 3);
    botoes = oh(exp_seq[1] + 2'd1);
    tick();
    chk("wrong_estado", 32'(db_estado), 6);
    chk("wrong_perdeu", 32'(perdeu), 1);
    chk("wrong_timeout", 32'(timeout), 0);
    chk("wrong_endereco", 32'(db_endereco), 1);
    chk("wrong_pronto", 32'(pronto), 1);
    botoes = 4'd0;
    tick();

    // Game 3: restart from PERDEU, then two buttons at once.
    start_game();
    chk("restart_perdeu_clear", 32'(perdeu), 0);
    check_replay(0);
    botoes = 4'b0011;
    tick();
    chk("multi_estado", 32'(db_estado), 6);
    chk("multi_perdeu", 32'(perdeu), 1);
    botoes = 4'd0;
    tick();

    // Game 4: no press in ESPERA.
    start_game();
    check_replay(0);
`ifdef JOGO_MEMORIA_TIMEOUT_EN
    repeat (TIMEOUT_CYCLES - 1) tick();
    chk("pre_timeout_estado", 32'(db_estado), 3);
    chk("pre_timeout_perdeu", 32'(perdeu), 0);
    tick();
    chk("timeout_estado", 32'(db_estado), 6);
    chk("timeout_perdeu", 32'(perdeu), 1);
    chk("timeout_flag", 32'(timeout), 1);
`else
    repeat (100) tick();
    chk("no_timeout_estado", 32'(db_estado), 3);
    chk("no_timeout_flag", 32'(timeout), 0);
`endif
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("reset_from_wait_estado", 32'(db_estado), 0);
    chk("reset_from_wait_flags", 32'({ganhou, perdeu, timeout}), 0);

    // Game 5: reset in the middle of MOSTRA.
    start_game();
    tick();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("iniciar_ignored_mostra", 32'(db_estado), 2);
    reset = 1'b0;
    tick();
    chk("mid_reset_estado", 32'(db_estado), 0);
    chk("mid_reset_leds", 32'(leds), 0);
    chk("mid_reset_pronto", 32'(pronto), 1);
    chk("mid_reset_db", 32'({db_rodada, db_endereco}), 0);
    reset = 1'b1;
    tick();
    chk("post_reset_idle", 32'(db_estado), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
